// File: rtl/dac_spi_serializer_pkg.sv
// Shared constants, state encoding and frame builder for the MCP4822 SPI serializer.
package dac_spi_serializer_pkg;

  localparam int unsigned FRAME_W    = 16;
  localparam int unsigned DATA_W     = 12;
  localparam int unsigned BIT_CNT_W  = 4;
  localparam int unsigned CH_BIT     = 15;
  localparam int unsigned GA_N_BIT   = 13;
  localparam int unsigned SHDN_N_BIT = 12;
  localparam int unsigned STATE_W    = 3;

  typedef logic [STATE_W-1:0] dac_state_t;

  localparam dac_state_t ST_IDLE       = 3'd0;
  localparam dac_state_t ST_CS_SETUP   = 3'd1;
  localparam dac_state_t ST_SHIFT      = 3'd2;
  localparam dac_state_t ST_CS_HOLD    = 3'd3;
  localparam dac_state_t ST_CS_GAP     = 3'd4;
  localparam dac_state_t ST_LDAC_PULSE = 3'd5;

  // MCP4822 command word: {ch, 0, GA_n, SHDN_n, data}
  function automatic logic [FRAME_W-1:0] build_frame(input logic              ch,
                                                     input logic              gain2x,
                                                     input logic              en,
                                                     input logic [DATA_W-1:0] data);
    logic [FRAME_W-1:0] f;
    f             = '0;
    f[CH_BIT]     = ch;
    f[GA_N_BIT]   = ~gain2x;
    f[SHDN_N_BIT] = en;
    f[DATA_W-1:0] = data;
    return f;
  endfunction

endpackage

// File: rtl/dac_spi_serializer_if.sv
// Sample-pair handshake from the waveform generator into the DAC serializer.
interface dac_spi_serializer_if;
  import dac_spi_serializer_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] sample_a;
  logic [DATA_W-1:0] sample_b;
  logic              gain2x_a;
  logic              gain2x_b;
  logic              en_a;
  logic              en_b;

  modport master (
    output in_valid, sample_a, sample_b, gain2x_a, gain2x_b, en_a, en_b,
    input  in_ready
  );

  modport slave (
    input  in_valid, sample_a, sample_b, gain2x_a, gain2x_b, en_a, en_b,
    output in_ready
  );

endinterface

// File: rtl/dac_spi_serializer_half_tick.sv
// SCK half-period timer: tick on the last of every CLK_DIV cycles, restarted by i_load.
module dac_spi_serializer_half_tick #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic resetn,
  input  logic i_load,
  output logic o_tick_c
);

  localparam int unsigned CNT_W = $clog2(CLK_DIV + 1);
  localparam logic [CNT_W-1:0] TERM = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt <= '0;
    end else if (i_load || (r_cnt == TERM)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_tick_c = (r_cnt == TERM);

endmodule

// File: rtl/dac_spi_serializer.sv
// Serializes one A/B sample pair into two MCP4822 SPI frames, then pulses ldac so both
// outputs update together.
module dac_spi_serializer
  import dac_spi_serializer_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic                 clk,
  input  logic                 resetn,
  dac_spi_serializer_if.slave  bus,
  output logic                 cs,
  output logic                 spi_clk_out,
  output logic                 sdi,
  output logic                 ldac,
  output logic                 frame_done
);

  if (CLK_DIV < 1) begin : g_bad_clk_div
    $error("dac_spi_serializer: CLK_DIV must be >= 1");
  end

  dac_state_t           r_state,   w_state_nxt;
  logic                 r_cs,      w_cs_nxt;
  logic                 r_sck,     w_sck_nxt;
  logic                 r_ldac,    w_ldac_nxt;
  logic                 r_done,    w_done_nxt;
  logic                 r_rdy,     w_rdy_nxt;
  logic                 r_is_b,    w_is_b_nxt;
  logic [BIT_CNT_W-1:0] r_bit_cnt, w_bit_cnt_nxt;
  logic [FRAME_W-1:0]   r_shift,   w_shift_nxt;
  logic [FRAME_W-1:0]   r_frame_b, w_frame_b_nxt;
  logic                 w_accept;
  logic                 w_tick;

  dac_spi_serializer_half_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_half_tick (
    .clk      (clk),
    .resetn   (resetn),
    .i_load   (w_accept),
    .o_tick_c (w_tick)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= ST_IDLE;
      r_cs      <= 1'b1;
      r_sck     <= 1'b0;
      r_ldac    <= 1'b1;
      r_done    <= 1'b0;
      r_rdy     <= 1'b1;
      r_is_b    <= 1'b0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_frame_b <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cs      <= w_cs_nxt;
      r_sck     <= w_sck_nxt;
      r_ldac    <= w_ldac_nxt;
      r_done    <= w_done_nxt;
      r_rdy     <= w_rdy_nxt;
      r_is_b    <= w_is_b_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_shift   <= w_shift_nxt;
      r_frame_b <= w_frame_b_nxt;
    end
  end

  // Frame A goes straight into the shift register at accept; only frame B needs holding.
  always_comb begin
    w_state_nxt   = r_state;
    w_cs_nxt      = r_cs;
    w_sck_nxt     = r_sck;
    w_ldac_nxt    = r_ldac;
    w_done_nxt    = 1'b0;
    w_rdy_nxt     = r_rdy;
    w_is_b_nxt    = r_is_b;
    w_bit_cnt_nxt = r_bit_cnt;
    w_shift_nxt   = r_shift;
    w_frame_b_nxt = r_frame_b;
    w_accept      = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (bus.in_valid) begin
          w_accept      = 1'b1;
          w_state_nxt   = ST_CS_SETUP;
          w_cs_nxt      = 1'b0;
          w_rdy_nxt     = 1'b0;
          w_is_b_nxt    = 1'b0;
          w_shift_nxt   = build_frame(1'b0, bus.gain2x_a, bus.en_a, bus.sample_a);
          w_frame_b_nxt = build_frame(1'b1, bus.gain2x_b, bus.en_b, bus.sample_b);
        end
      end
      ST_CS_SETUP: begin
        if (w_tick) begin
          w_state_nxt   = ST_SHIFT;
          w_sck_nxt     = 1'b1;
          w_bit_cnt_nxt = BIT_CNT_W'(FRAME_W - 1);
        end
      end
      ST_SHIFT: begin
        // sdi advances on the falling edge; bit 0 keeps its value through the final low phase
        if (w_tick) begin
          if (r_sck) begin
            w_sck_nxt = 1'b0;
            if (r_bit_cnt != '0) begin
              w_shift_nxt = {r_shift[FRAME_W-2:0], 1'b0};
            end
          end else if (r_bit_cnt == '0) begin
            w_state_nxt = ST_CS_HOLD;
          end else begin
            w_sck_nxt     = 1'b1;
            w_bit_cnt_nxt = r_bit_cnt - BIT_CNT_W'(1);
          end
        end
      end
      ST_CS_HOLD: begin
        if (w_tick) begin
          w_state_nxt = ST_CS_GAP;
          w_cs_nxt    = 1'b1;
          w_shift_nxt = '0;
        end
      end
      ST_CS_GAP: begin
        if (w_tick) begin
          if (!r_is_b) begin
            w_state_nxt = ST_CS_SETUP;
            w_cs_nxt    = 1'b0;
            w_is_b_nxt  = 1'b1;
            w_shift_nxt = r_frame_b;
          end else begin
            w_state_nxt = ST_LDAC_PULSE;
            w_ldac_nxt  = 1'b0;
          end
        end
      end
      ST_LDAC_PULSE: begin
        if (w_tick) begin
          w_state_nxt = ST_IDLE;
          w_ldac_nxt  = 1'b1;
          w_done_nxt  = 1'b1;
          w_rdy_nxt   = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign bus.in_ready = r_rdy;
  assign cs           = r_cs;
  assign spi_clk_out  = r_sck;
  assign sdi          = r_shift[FRAME_W-1];
  assign ldac         = r_ldac;
  assign frame_done   = r_done;

endmodule

// File: tb/tb_dac_spi_serializer.sv
// Directed bench for dac_spi_serializer: SPI-decoding monitor plus vector table and
// hand-written back-to-back, mid-frame reset and CLK_DIV=1 sequences.
`timescale 1ns/1ps
module tb_dac_spi_serializer;

  typedef struct {
    logic [11:0] sa;
    logic [11:0] sb;
    logic        g_a;
    logic        g_b;
    logic        en_a;
    logic        en_b;
    logic [15:0] exp_a;
    logic [15:0] exp_b;
  } vec_t;

  logic clk;
  logic resetn;
  int   cyc;
  int   checks;
  int   failures;

  dac_spi_serializer_if bus0 ();
  dac_spi_serializer_if bus1 ();

  logic cs0, sck0, sdi0, ldac0, done0;
  logic cs1, sck1, sdi1, ldac1, done1;

  dac_spi_serializer #(.CLK_DIV(4)) dut4 (
    .clk(clk), .resetn(resetn), .bus(bus0),
    .cs(cs0), .spi_clk_out(sck0), .sdi(sdi0), .ldac(ldac0), .frame_done(done0)
  );

  dac_spi_serializer #(.CLK_DIV(1)) dut1 (
    .clk(clk), .resetn(resetn), .bus(bus1),
    .cs(cs1), .spi_clk_out(sck1), .sdi(sdi1), .ldac(ldac1), .frame_done(done1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- SPI monitor (both instances, sampled on negedge) ----------------
  logic        m_cs [2], m_sck [2], m_sdi [2], m_ldac [2], m_done [2];
  assign m_cs[0] = cs0;   assign m_sck[0] = sck0;  assign m_sdi[0] = sdi0;
  assign m_ldac[0] = ldac0; assign m_done[0] = done0;
  assign m_cs[1] = cs1;   assign m_sck[1] = sck1;  assign m_sdi[1] = sdi1;
  assign m_ldac[1] = ldac1; assign m_done[1] = done1;

  logic        p_cs [2], p_sck [2], p_sdi [2], p_ldac [2];
  logic [15:0] m_word [2];
  int          m_bits [2];
  logic [15:0] fr_log [2][32];
  int          fr_bits [2][32];
  int          fr_n [2];
  int          ldac_len [2][32];
  int          ldac_n [2];
  int          ldac_run [2];
  int          done_n [2];
  int          stray [2];
  int          viol [2];
  int          tog [2];
  int          age [2];
  int          hold_left [2];
  logic        hold_val [2];

  function automatic int h_of(input int d);
    return (d == 0) ? 4 : 1;
  endfunction

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!resetn) begin
        m_bits[d]    = 0;
        m_word[d]    = '0;
        hold_left[d] = 0;
        ldac_run[d]  = 0;
        age[d]       = 0;
      end else begin
        if (m_sdi[d] !== p_sdi[d]) age[d] = 0; else age[d]++;
        if (m_cs[d] !== p_cs[d] || m_sck[d] !== p_sck[d] ||
            m_sdi[d] !== p_sdi[d] || m_ldac[d] !== p_ldac[d]) tog[d]++;
        if (!m_cs[d] && p_cs[d]) begin
          m_bits[d] = 0;
          m_word[d] = '0;
        end
        if (m_sck[d] && !p_sck[d]) begin
          if (m_cs[d]) stray[d]++;
          else begin
            m_word[d] = {m_word[d][14:0], m_sdi[d]};
            m_bits[d]++;
          end
          if (age[d] < h_of(d)) viol[d]++;
          hold_left[d] = h_of(d);
          hold_val[d]  = m_sdi[d];
        end
        if (hold_left[d] > 0) begin
          if (m_sdi[d] !== hold_val[d]) viol[d]++;
          hold_left[d]--;
        end
        if (m_cs[d] && !p_cs[d] && fr_n[d] < 32) begin
          fr_log[d][fr_n[d]]  = m_word[d];
          fr_bits[d][fr_n[d]] = m_bits[d];
          fr_n[d]++;
        end
        if (!m_ldac[d]) ldac_run[d]++;
        if (m_ldac[d] && !p_ldac[d] && ldac_n[d] < 32) begin
          ldac_len[d][ldac_n[d]] = ldac_run[d];
          ldac_n[d]++;
          ldac_run[d] = 0;
        end
        if (m_done[d]) done_n[d]++;
      end
      p_cs[d]   = m_cs[d];
      p_sck[d]  = m_sck[d];
      p_sdi[d]  = m_sdi[d];
      p_ldac[d] = m_ldac[d];
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [11:0] sa, input logic [11:0] sb,
                              input logic g_a, input logic g_b,
                              input logic en_a, input logic en_b,
                              input logic [15:0] exp_a, input logic [15:0] exp_b);
    vec_t v;
    v.sa = sa; v.sb = sb; v.g_a = g_a; v.g_b = g_b;
    v.en_a = en_a; v.en_b = en_b; v.exp_a = exp_a; v.exp_b = exp_b;
    return v;
  endfunction

  task automatic drive(input int d, input logic valid, input vec_t x);
    if (d == 0) begin
      bus0.in_valid = valid; bus0.sample_a = x.sa; bus0.sample_b = x.sb;
      bus0.gain2x_a = x.g_a; bus0.gain2x_b = x.g_b; bus0.en_a = x.en_a; bus0.en_b = x.en_b;
    end else begin
      bus1.in_valid = valid; bus1.sample_a = x.sa; bus1.sample_b = x.sb;
      bus1.gain2x_a = x.g_a; bus1.gain2x_b = x.g_b; bus1.en_a = x.en_a; bus1.en_b = x.en_b;
    end
  endtask

  function automatic logic rdy(input int d);
    return (d == 0) ? bus0.in_ready : bus1.in_ready;
  endfunction

  // One accepted pair; caller is positioned at a negedge.
  task automatic run_pair(input int d, input vec_t x, input int exp_lat, input string tag);
    int guard, lat, f0, l0, dn0;
    guard = 0;
    while (!rdy(d) && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    chk({tag, " ready_before"}, 32'(rdy(d)), 32'd1);
    f0 = fr_n[d]; l0 = ldac_n[d]; dn0 = done_n[d];
    drive(d, 1'b1, x);
    @(negedge clk);
    drive(d, 1'b0, x);
    lat = 0;
    while (!rdy(d) && lat < 2000) begin
      @(negedge clk);
      lat++;
    end
    repeat (3) @(negedge clk);
    chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, " frame_count"}, 32'(fr_n[d] - f0), 32'd2);
    chk({tag, " frame_a"}, 32'(fr_log[d][f0 & 31]), 32'(x.exp_a));
    chk({tag, " frame_b"}, 32'(fr_log[d][(f0 + 1) & 31]), 32'(x.exp_b));
    chk({tag, " bits_a"}, 32'(fr_bits[d][f0 & 31]), 32'd16);
    chk({tag, " bits_b"}, 32'(fr_bits[d][(f0 + 1) & 31]), 32'd16);
    chk({tag, " ldac_pulses"}, 32'(ldac_n[d] - l0), 32'd1);
    chk({tag, " ldac_width"}, 32'(ldac_len[d][l0 & 31]), 32'(h_of(d)));
    chk({tag, " frame_done"}, 32'(done_n[d] - dn0), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    vec_t        vecs [4];
    vec_t        v;
    logic [11:0] b2b_s [3];
    int          acc [3];
    int          f0, l0, dn0, t0, guard;

    vecs[0] = mk(12'hABC, 12'h123, 1'b0, 1'b1, 1'b1, 1'b1, 16'h3ABC, 16'h9123);
    vecs[1] = mk(12'hFFF, 12'h123, 1'b0, 1'b0, 1'b0, 1'b1, 16'h2FFF, 16'hB123);
    vecs[2] = mk(12'h000, 12'hFFF, 1'b1, 1'b0, 1'b1, 1'b0, 16'h1000, 16'hAFFF);
    vecs[3] = mk(12'h555, 12'hAAA, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0555, 16'h9AAA);
    b2b_s[0] = 12'h000; b2b_s[1] = 12'h800; b2b_s[2] = 12'hFFF;

    checks = 0; failures = 0;
    resetn = 1'b0;
    drive(0, 1'b0, vecs[0]);
    drive(1, 1'b0, vecs[0]);
    repeat (3) @(negedge clk);
    chk("reset cs", 32'(cs0), 32'd1);
    chk("reset sck", 32'(sck0), 32'd0);
    chk("reset sdi", 32'(sdi0), 32'd0);
    chk("reset ldac", 32'(ldac0), 32'd1);
    chk("reset in_ready", 32'(bus0.in_ready), 32'd1);
    chk("reset frame_done", 32'(done0), 32'd0);

    resetn = 1'b1;
    @(negedge clk);
    t0 = tog[0];
    repeat (100) @(negedge clk);
    chk("idle toggles", 32'(tog[0] - t0), 32'd0);
    chk("idle cs", 32'(cs0), 32'd1);
    chk("idle ldac", 32'(ldac0), 32'd1);
    chk("idle sck", 32'(sck0), 32'd0);
    chk("idle in_ready", 32'(bus0.in_ready), 32'd1);
    chk("idle frames", 32'(fr_n[0]), 32'd0);

    for (int i = 0; i < 4; i++) begin
      run_pair(0, vecs[i], 284, $sformatf("vec%0d", i));
    end

    // in_valid held high across three transactions
    f0 = fr_n[0]; l0 = ldac_n[0]; dn0 = done_n[0];
    v = mk(b2b_s[0], b2b_s[0], 1'b0, 1'b0, 1'b1, 1'b1, 16'h0, 16'h0);
    drive(0, 1'b1, v);
    for (int k = 0; k < 3; k++) begin
      guard = 0;
      while (!bus0.in_ready && guard < 1000) begin
        @(negedge clk);
        guard++;
      end
      acc[k] = cyc;
      @(negedge clk);
      if (k < 2) begin
        v = mk(b2b_s[k + 1], b2b_s[k + 1], 1'b0, 1'b0, 1'b1, 1'b1, 16'h0, 16'h0);
        drive(0, 1'b1, v);
      end else begin
        drive(0, 1'b0, v);
      end
    end
    guard = 0;
    while (!bus0.in_ready && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    repeat (20) @(negedge clk);
    chk("b2b spacing01", 32'(acc[1] - acc[0]), 32'd285);
    chk("b2b spacing12", 32'(acc[2] - acc[1]), 32'd285);
    chk("b2b frame_count", 32'(fr_n[0] - f0), 32'd6);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("b2b%0d frame_a", k), 32'(fr_log[0][(f0 + 2 * k) & 31]),
          32'(16'h3000 | {4'h0, b2b_s[k]}));
      chk($sformatf("b2b%0d frame_b", k), 32'(fr_log[0][(f0 + 2 * k + 1) & 31]),
          32'(16'hB000 | {4'h0, b2b_s[k]}));
    end
    chk("b2b frame_done", 32'(done_n[0] - dn0), 32'd3);
    chk("b2b ldac_pulses", 32'(ldac_n[0] - l0), 32'd3);

    // reset during bit 7 of frame B
    f0 = fr_n[0]; l0 = ldac_n[0]; dn0 = done_n[0];
    drive(0, 1'b1, vecs[0]);
    @(negedge clk);
    drive(0, 1'b0, vecs[0]);
    repeat (209) @(negedge clk);
    chk("midrst bits_seen", 32'(m_bits[0]), 32'd9);
    chk("midrst sck_high", 32'(sck0), 32'd1);
    resetn = 1'b0;
    #1;
    chk("midrst cs", 32'(cs0), 32'd1);
    chk("midrst sck", 32'(sck0), 32'd0);
    chk("midrst sdi", 32'(sdi0), 32'd0);
    chk("midrst ldac", 32'(ldac0), 32'd1);
    chk("midrst in_ready", 32'(bus0.in_ready), 32'd1);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (20) @(negedge clk);
    chk("midrst no_ldac", 32'(ldac_n[0] - l0), 32'd0);
    chk("midrst no_done", 32'(done_n[0] - dn0), 32'd0);
    chk("midrst frames", 32'(fr_n[0] - f0), 32'd1);
    chk("midrst frame_a", 32'(fr_log[0][f0 & 31]), 32'h3ABC);
    run_pair(0, vecs[1], 284, "after_rst");

    // fastest divider
    run_pair(1, vecs[0], 71, "div1_v0");
    run_pair(1, vecs[2], 71, "div1_v2");

    chk("stray sck div4", 32'(stray[0]), 32'd0);
    chk("stray sck div1", 32'(stray[1]), 32'd0);
    chk("sdi stability div4", 32'(viol[0]), 32'd0);
    chk("sdi stability div1", 32'(viol[1]), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
